fp_dispatch_controller: RTL

//  Sequences the fixed-priority queue selector: waits for its registered priority view to settle,

---
 rtl/fp_dispatch_controller_if.sv | 30 +++
 rtl/fp_dispatch_controller.sv | 95 +++++++++
 2 files changed

// File: rtl/fp_dispatch_controller_if.sv
// Handshake bundle between the fixed-priority dispatch controller, its queue selector
// and the memory-request issue port.
interface fp_dispatch_controller_if #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int COUNT_WIDTH      = 16
);
    localparam int ID_WIDTH = $clog2(NUMBER_OF_QUEUES);

    logic                        enable;
    logic [NUMBER_OF_QUEUES-1:0] empty;
    logic                        sel_valid;
    logic [ID_WIDTH-1:0]         selection;
    logic                        out_valid;
    logic [ID_WIDTH-1:0]         out_id;
    logic                        out_ready;
    logic [NUMBER_OF_QUEUES-1:0] pop;
    logic                        busy;
    logic [COUNT_WIDTH-1:0]      grant_count;
    logic                        error;

    modport master (
        input  enable, empty, sel_valid, selection, out_ready,
        output out_valid, out_id, pop, busy, grant_count, error
    );

    modport slave (
        output enable, empty, sel_valid, selection, out_ready,
        input  out_valid, out_id, pop, busy, grant_count, error
    );
endinterface

// File: rtl/fp_dispatch_controller.sv
// Waits for the registered priority view to settle, latches the winning queue id,
// offers it downstream and pops exactly one packet per completed handshake.
module fp_dispatch_controller #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int SETTLE_CYCLES    = 2,
    parameter int COUNT_WIDTH      = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    fp_dispatch_controller_if.master bus
);
    localparam int ID_WIDTH = $clog2(NUMBER_OF_QUEUES);
    localparam int CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GRANT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ID_WIDTH-1:0]    out_id_q, out_id_d;
    logic [COUNT_WIDTH-1:0] grant_count_q, grant_count_d;
    logic                   error_q, error_d;
    logic                   handshake;
    logic                   selection_ok;

    // out_valid is a pure decode of the state register so an async reset withdraws it at once.
    assign bus.out_valid   = (state_q == GRANT);
    assign bus.out_id      = out_id_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.grant_count = grant_count_q;
    assign bus.error       = error_q;
    assign handshake       = bus.out_valid && bus.out_ready;
    assign bus.pop         = handshake ? (NUMBER_OF_QUEUES'(1) << out_id_q) : '0;

    assign selection_ok = (int'(bus.selection) < NUMBER_OF_QUEUES) && !bus.empty[bus.selection];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            out_id_q      <= '0;
            grant_count_q <= '0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_id_q      <= out_id_d;
            grant_count_q <= grant_count_d;
            error_q       <= error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        out_id_d      = out_id_q;
        grant_count_d = grant_count_q;
        error_d       = error_q;

        unique case (state_q)
            IDLE: begin
                if (bus.enable && bus.sel_valid) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_START;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (bus.enable && bus.sel_valid && selection_ok) begin
                    state_d  = GRANT;
                    out_id_d = bus.selection;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                // A queue draining underneath an offered grant is flagged, but the grant stays up.
                if (bus.empty[out_id_q]) begin
                    error_d = 1'b1;
                end
                if (handshake) begin
                    state_d       = SETTLE;
                    cnt_d         = CNT_START;
                    grant_count_d = grant_count_q + COUNT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
